// File: rtl/t03_fetch.sv
// Instruction fetch stage: one outstanding memory request, result held for decode.
// Latency: request issued the cycle after the address is sampled; word visible the cycle after instrAck.
// Backpressure: stall=1 in HOLD freezes the delivered word and keeps freezePc high.
module t03_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetchAddr,
  input  logic        stall,
  output logic        instrReq,
  output logic [31:0] instrAddr,
  input  logic        instrAck,
  input  logic [31:0] instrData,
  output logic [31:0] instruction,
  output logic        instrValid,
  output logic        freezePc,
  output logic        fetchFault
);

  // Counter is at least 8 bits, wider only if the timeout needs it.
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             addr_aligned;

  assign addr_aligned = (fetchAddr[1:0] == 2'b00);

  // Next-state logic: sample the PC in IDLE or on a consume cycle, wait for ack or timeout in REQ.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (addr_aligned) begin
          addr_d  = fetchAddr;
          state_d = REQ;
        end else begin
          instr_d = NOP_INSTR;
          state_d = FAULT;
        end
      end
      REQ: begin
        // Ack is checked first so it wins over a timeout in the same cycle.
        if (instrAck) begin
          instr_d = instrData;
          cnt_d   = '0;
          state_d = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          instr_d = NOP_INSTR;
          cnt_d   = '0;
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          if (addr_aligned) begin
            addr_d  = fetchAddr;
            state_d = REQ;
          end else begin
            instr_d = NOP_INSTR;
            state_d = FAULT;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset overrides any ack or stall seen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      instr_q <= NOP_INSTR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from the state flop, except freezePc which must react to stall in-cycle.
  assign instrReq    = (state_q == REQ);
  assign instrValid  = (state_q == HOLD);
  assign fetchFault  = (state_q == FAULT);
  assign freezePc    = !((state_q == HOLD) && !stall);
  assign instrAddr   = addr_q;
  assign instruction = instr_q;

endmodule

// File: tb/tb_t03_fetch.sv
// Bench for t03_fetch: directed vector table plus randomized run against a reference model.
// Latency: checks each cycle at posedge+4 against expected outputs for that cycle.
// Backpressure: stall and ack are driven directly; no flow control in the bench itself.
module tb_t03_fetch;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetchAddr;
  logic        stall;
  logic        instrReq;
  logic [31:0] instrAddr;
  logic        instrAck;
  logic [31:0] instrData;
  logic [31:0] instruction;
  logic        instrValid;
  logic        freezePc;
  logic        fetchFault;

  int checks = 0;
  int errs   = 0;

  t03_fetch #(.TIMEOUT_CYCLES(TO), .NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetchAddr  (fetchAddr),
    .stall      (stall),
    .instrReq   (instrReq),
    .instrAddr  (instrAddr),
    .instrAck   (instrAck),
    .instrData  (instrData),
    .instruction(instruction),
    .instrValid (instrValid),
    .freezePc   (freezePc),
    .fetchFault (fetchFault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] fa;
    logic        stall;
    logic        ack;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        valid;
    logic        freeze;
    logic        fault;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [31:0] fa, logic st, logic ak, logic [31:0] d,
                              logic req, logic [31:0] addr, logic [31:0] ins,
                              logic vl, logic fz, logic ft);
    vec_t v;
    v.rst = r; v.fa = fa; v.stall = st; v.ack = ak; v.data = d;
    v.req = req; v.addr = addr; v.instr = ins; v.valid = vl; v.freeze = fz; v.fault = ft;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic req, logic [31:0] addr, logic [31:0] ins,
                         logic vl, logic fz, logic ft);
    chk({tag, ".instrReq"},    32'(instrReq),   32'(req));
    chk({tag, ".instrAddr"},   instrAddr,       addr);
    chk({tag, ".instruction"}, instruction,     ins);
    chk({tag, ".instrValid"},  32'(instrValid), 32'(vl));
    chk({tag, ".freezePc"},    32'(freezePc),   32'(fz));
    chk({tag, ".fetchFault"},  32'(fetchFault), 32'(ft));
  endtask

  // Reference model: an outstanding-request flag, a held-word flag and a sticky fault,
  // with a plain wait counter for the timeout rule.
  logic        m_fault, m_waiting, m_have;
  int          m_waited;
  logic [31:0] m_addr, m_instr;

  task automatic m_reset();
    m_fault = 0; m_waiting = 0; m_have = 0; m_waited = 0; m_addr = 0; m_instr = NOP;
  endtask

  task automatic m_sample(logic [31:0] fa);
    if (fa % 4 == 0) begin
      m_addr = fa;
      m_waiting = 1;
    end else begin
      m_fault = 1;
      m_instr = NOP;
    end
  endtask

  task automatic m_clock(logic r, logic [31:0] fa, logic st, logic ak, logic [31:0] d);
    if (r) m_reset();
    else if (m_fault) begin
    end else if (m_waiting) begin
      if (ak) begin
        m_instr = d; m_waiting = 0; m_have = 1; m_waited = 0;
      end else if (m_waited + 1 >= int'(TO)) begin
        m_fault = 1; m_waiting = 0; m_instr = NOP; m_waited = 0;
      end else begin
        m_waited++;
      end
    end else if (m_have) begin
      if (!st) begin
        m_have = 0;
        m_sample(fa);
      end
    end else begin
      m_sample(fa);
    end
  endtask

  localparam logic [31:0] D1 = 32'h00500093;
  localparam logic [31:0] D2 = 32'h00a00113;
  localparam logic [31:0] D3 = 32'h00f00193;
  localparam logic [31:0] D4 = 32'h12345678;

  initial begin
    rst = 1; fetchAddr = 0; stall = 0; instrAck = 0; instrData = 0;

    // Basic fetch, ack two cycles after the request rises, then a five-cycle stall.
    tbl.push_back(mk(0, 32'h0, 0, 0, 0,  0, 32'h0, NOP, 0, 1, 0));
    tbl.push_back(mk(0, 32'h0, 0, 0, 0,  1, 32'h0, NOP, 0, 1, 0));
    tbl.push_back(mk(0, 32'h0, 0, 0, 0,  1, 32'h0, NOP, 0, 1, 0));
    tbl.push_back(mk(0, 32'h0, 0, 1, D1, 1, 32'h0, NOP, 0, 1, 0));
    tbl.push_back(mk(0, 32'h0, 1, 0, 0,  0, 32'h0, D1,  1, 1, 0));
    tbl.push_back(mk(0, 32'h0, 1, 0, 0,  0, 32'h0, D1,  1, 1, 0));
    tbl.push_back(mk(0, 32'h0, 1, 1, 32'hffffffff, 0, 32'h0, D1, 1, 1, 0));
    tbl.push_back(mk(0, 32'h0, 1, 0, 0,  0, 32'h0, D1,  1, 1, 0));
    tbl.push_back(mk(0, 32'h0, 1, 0, 0,  0, 32'h0, D1,  1, 1, 0));
    // Consume, then back-to-back single-cycle acks at 0x4 and 0x8.
    tbl.push_back(mk(0, 32'h4, 0, 0, 0,  0, 32'h0, D1,  1, 0, 0));
    tbl.push_back(mk(0, 32'h4, 0, 1, D2, 1, 32'h4, D1,  0, 1, 0));
    tbl.push_back(mk(0, 32'h8, 0, 0, 0,  0, 32'h4, D2,  1, 0, 0));
    tbl.push_back(mk(0, 32'h8, 0, 1, D3, 1, 32'h8, D2,  0, 1, 0));
    tbl.push_back(mk(0, 32'hc, 0, 0, 0,  0, 32'h8, D3,  1, 0, 0));
    // Request to 0xC never acked: four request cycles then fault; stall ignored in REQ.
    tbl.push_back(mk(0, 32'hc, 0, 0, 0,  1, 32'hc, D3,  0, 1, 0));
    tbl.push_back(mk(0, 32'hc, 1, 0, 0,  1, 32'hc, D3,  0, 1, 0));
    tbl.push_back(mk(0, 32'hc, 0, 0, 0,  1, 32'hc, D3,  0, 1, 0));
    tbl.push_back(mk(0, 32'hc, 0, 0, 0,  1, 32'hc, D3,  0, 1, 0));
    tbl.push_back(mk(0, 32'hc, 0, 1, D4, 0, 32'hc, NOP, 0, 1, 1));
    tbl.push_back(mk(0, 32'hc, 0, 0, 0,  0, 32'hc, NOP, 0, 1, 1));
    // Reset out of fault, then a misaligned address in IDLE.
    tbl.push_back(mk(1, 32'h6, 0, 0, 0,  0, 32'hc, NOP, 0, 1, 1));
    tbl.push_back(mk(0, 32'h6, 0, 0, 0,  0, 32'h0, NOP, 0, 1, 0));
    tbl.push_back(mk(0, 32'h6, 0, 0, 0,  0, 32'h0, NOP, 0, 1, 1));
    tbl.push_back(mk(0, 32'h6, 0, 0, 0,  0, 32'h0, NOP, 0, 1, 1));
    // Ack on the last allowed request cycle wins over the timeout.
    tbl.push_back(mk(1, 32'h10, 0, 0, 0, 0, 32'h0,  NOP, 0, 1, 1));
    tbl.push_back(mk(0, 32'h10, 0, 0, 0, 0, 32'h0,  NOP, 0, 1, 0));
    tbl.push_back(mk(0, 32'h10, 0, 0, 0, 1, 32'h10, NOP, 0, 1, 0));
    tbl.push_back(mk(0, 32'h10, 0, 0, 0, 1, 32'h10, NOP, 0, 1, 0));
    tbl.push_back(mk(0, 32'h10, 0, 0, 0, 1, 32'h10, NOP, 0, 1, 0));
    tbl.push_back(mk(0, 32'h10, 0, 1, D4, 1, 32'h10, NOP, 0, 1, 0));
    tbl.push_back(mk(0, 32'h20, 1, 0, 0, 0, 32'h10, D4,  1, 1, 0));
    tbl.push_back(mk(0, 32'h20, 0, 0, 0, 0, 32'h10, D4,  1, 0, 0));
    // Reset mid-request with a simultaneous ack: ack dropped, refetch after one IDLE cycle.
    tbl.push_back(mk(1, 32'h24, 0, 1, 32'hdeadbeef, 1, 32'h20, D4, 0, 1, 0));
    tbl.push_back(mk(0, 32'h24, 0, 0, 0, 0, 32'h0,  NOP, 0, 1, 0));
    tbl.push_back(mk(0, 32'h24, 0, 0, 0, 1, 32'h24, NOP, 0, 1, 0));

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; fetchAddr = tbl[i].fa; stall = tbl[i].stall;
      instrAck = tbl[i].ack; instrData = tbl[i].data;
      #3;
      chk_all($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].instr,
              tbl[i].valid, tbl[i].freeze, tbl[i].fault);
      @(posedge clk); #1;
    end

    // Randomized run against the reference model.
    rst = 1; instrAck = 0; stall = 0; fetchAddr = 0;
    @(posedge clk); #1;
    m_reset();
    for (int c = 0; c < 800; c++) begin
      logic        r;
      logic [31:0] fa;
      r  = m_fault ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 79) == 0);
      fa = $urandom() & 32'hffff_fffc;
      if ($urandom_range(0, 24) == 0) fa = fa | 32'($urandom_range(1, 3));
      rst = r; fetchAddr = fa;
      stall = 1'($urandom_range(0, 1));
      instrAck = ($urandom_range(0, 9) < 3);
      instrData = $urandom();
      #3;
      chk_all($sformatf("rnd%0d", c), m_waiting, m_addr, m_instr,
              m_have, !(m_have && !stall), m_fault);
      m_clock(rst, fetchAddr, stall, instrAck, instrData);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/t03_fetch.md
T03_FETCH -- requirements
Module: t03_fetch

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles in REQ without instrAck before a fault.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, meaning the instruction word driven when no valid fetch is held.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 SHALL have port fetchAddr  input  32  byte address of the next instruction, driven by the PC stage.
REQ-006 SHALL have port stall  input  1  downstream hazard; 1 holds the current instruction.
REQ-007 SHALL have port instrReq  output  1  instruction-memory request strobe.
REQ-008 SHALL have port instrAddr  output  32  registered request address.
REQ-009 SHALL have port instrAck  input  1  memory completion; instrData is valid in the same cycle.
REQ-010 SHALL have port instrData  input  32  instruction word from memory.
REQ-011 SHALL have port instruction  output  32  registered instruction delivered to decode.
REQ-012 SHALL have port instrValid  output  1  instruction holds a fetched word.
REQ-013 SHALL have port freezePc  output  1  PC hold; 0 only in a consume cycle.
REQ-014 SHALL have port fetchFault  output  1  sticky fault flag for a misaligned address or a timeout.

Function
REQ-015 SHALL implement the states IDLE, REQ, HOLD and FAULT, with a 2-bit state register.
REQ-016 IDLE SHALL last exactly 1 cycle after reset, then sample fetchAddr: if fetchAddr[1:0]==0, instrAddr<=fetchAddr and go to REQ; otherwise go to FAULT.
REQ-017 REQ SHALL drive instrReq=1 and hold instrAddr stable until instrAck.
REQ-018 REQ with instrAck=1 SHALL set instruction<=instrData, clear the timeout counter and go to HOLD; instrReq SHALL be 0 in the next cycle.
REQ-019 REQ with instrAck=0 SHALL increment an 8-bit (or wider) timeout counter; when the counter equals TIMEOUT_CYCLES-1 with no ack, the block SHALL go to FAULT.
REQ-020 If instrAck and the timeout occur in the same cycle, the ack SHALL win.
REQ-021 HOLD SHALL drive instrValid=1 and keep instruction constant while stall=1.
REQ-022 HOLD with stall=0 is the consume cycle: freezePc=0 combinationally in that cycle, and fetchAddr SHALL be sampled under the IDLE alignment rule, going to REQ or FAULT.
REQ-023 freezePc SHALL equal NOT(state==HOLD AND stall==0), combinational, with no other path to 0.
REQ-024 FAULT SHALL drive fetchFault=1, instrValid=0, instrReq=0, instruction=NOP_INSTR and freezePc=1, and SHALL hold until rst.
REQ-025 instrAck SHALL be ignored in IDLE, HOLD and FAULT.
REQ-026 instrValid SHALL be 0 in IDLE, REQ and FAULT, and instruction SHALL keep its last value in REQ.
REQ-027 stall SHALL have no effect outside HOLD.
REQ-028 Address arithmetic SHALL be pass-through only, with no offset added, since fetchAddr already includes any base address.

Reset
REQ-029 rst=1 at a rising edge SHALL force: state=IDLE, instrReq=0, instrAddr=0, instruction=NOP_INSTR, instrValid=0, fetchFault=0, timeout counter=0; freezePc=1 follows from state.
REQ-030 rst asserted during REQ SHALL abandon the request: instrReq=0 from the next cycle, and any instrAck in the reset cycle SHALL be ignored.
REQ-031 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-032 Reset, then fetchAddr=0, ack 2 cycles after instrReq rises with instrData=0x00500093 -> instrAddr=0, instrValid=1, instruction=0x00500093, and freezePc=0 only in the consume cycle.
REQ-033 In HOLD with stall=1 for 5 cycles, then stall=0 and fetchAddr=0x4 -> instruction stable for 5 cycles, freezePc=1 throughout, a single consume cycle, then instrReq=1 with instrAddr=0x4.
REQ-034 fetchAddr=0x6 sampled in IDLE -> FAULT next cycle, fetchFault=1, instrReq never asserted, instruction=0x00000013.
REQ-035 TIMEOUT_CYCLES=4 with no ack -> instrReq high for 4 cycles, then fetchFault=1; an ack arriving on the 4th cycle instead -> HOLD with no fault.
REQ-036 rst pulse mid-REQ with a simultaneous ack -> instruction=0x00000013, instrValid=0, and a new request to the current fetchAddr after 1 IDLE cycle.
REQ-037 Back-to-back: single-cycle acks, stall=0, fetchAddr stepping 0x0, 0x4, 0x8 -> one instruction delivered every 2 cycles, in order.
